// File: rtl/mem_req_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_req_arbiter_pkg
// Description : Shared types and size encodings for the memory request arbiter
// Revision    : 1.0 - initial release
// ============================================================================
package mem_req_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_WAIT = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_DATA = 1'b0,
        OWN_INST = 1'b1
    } owner_t;

    // Same encoding as the decoder's size_mem field
    localparam logic [1:0] MEM_SIZE_B = 2'd0;
    localparam logic [1:0] MEM_SIZE_H = 2'd1;
    localparam logic [1:0] MEM_SIZE_W = 2'd2;

endpackage
`default_nettype wire

// File: rtl/mem_req_arbiter_starve_cnt.sv
`default_nettype none
// ============================================================================
// Module      : mem_req_arbiter_starve_cnt
// Description : Saturating count of data grants made while fetch was waiting
// Revision    : 1.0 - initial release
// ============================================================================
module mem_req_arbiter_starve_cnt #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic i_aclk,
    input  logic i_aresetn,
    input  logic i_grant_data,
    input  logic i_grant_inst,
    input  logic i_inst_pending,
    output logic o_override
);

    localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] c_limit = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            r_cnt <= '0;
        end else if (i_grant_inst) begin
            r_cnt <= '0;
        end else if (i_grant_data) begin
            if (!i_inst_pending)
                r_cnt <= '0;
            else if (r_cnt != c_limit)
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // A zero limit disables the override entirely
    assign o_override = (STARVE_LIMIT != 0) && (r_cnt == c_limit);

endmodule
`default_nettype wire

// File: rtl/mem_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_req_arbiter
// Description : Two-requester (fetch / load-store) arbiter onto one memory port
// Revision    : 1.0 - initial release
// ============================================================================
module mem_req_arbiter
    import mem_req_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                inst_req,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic                inst_addr_ok,
    output logic                inst_data_ok,
    output logic [DATA_W-1:0]   inst_rdata,
    input  logic                data_req,
    input  logic                data_wr,
    input  logic [1:0]          data_size,
    input  logic [DATA_W/8-1:0] data_wstrb,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic                data_addr_ok,
    output logic                data_data_ok,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                bus_req,
    output logic                bus_wr,
    output logic [1:0]          bus_size,
    output logic [DATA_W/8-1:0] bus_wstrb,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    input  logic                bus_addr_ok,
    input  logic                bus_data_ok,
    input  logic [DATA_W-1:0]   bus_rdata,
    output logic                busy
);

    arb_state_t          r_state;
    arb_state_t          w_state_nxt;
    owner_t              r_owner;
    logic                r_bus_wr;
    logic [1:0]          r_bus_size;
    logic [DATA_W/8-1:0] r_bus_wstrb;
    logic [ADDR_W-1:0]   r_bus_addr;
    logic [DATA_W-1:0]   r_bus_wdata;
    logic [DATA_W-1:0]   r_inst_rdata;
    logic [DATA_W-1:0]   r_data_rdata;
    logic                w_idle;
    logic                w_override;
    logic                w_grant_data;
    logic                w_grant_inst;

    assign w_idle       = (r_state == ARB_IDLE);
    assign w_grant_data = w_idle && data_req && !(inst_req && w_override);
    assign w_grant_inst = w_idle && inst_req && !w_grant_data;

    mem_req_arbiter_starve_cnt #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_cnt (
        .i_aclk         (aclk),
        .i_aresetn      (aresetn),
        .i_grant_data   (w_grant_data),
        .i_grant_inst   (w_grant_inst),
        .i_inst_pending (inst_req),
        .o_override     (w_override)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            r_state <= ARB_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                inst_addr_ok = w_grant_inst;
                data_addr_ok = w_grant_data;
                if (w_grant_inst || w_grant_data)
                    w_state_nxt = ARB_REQ;
            end
            // A data response seen here is bus noise and is dropped
            ARB_REQ: begin
                if (bus_addr_ok)
                    w_state_nxt = ARB_WAIT;
            end
            ARB_WAIT: begin
                if (bus_data_ok) begin
                    inst_data_ok = (r_owner == OWN_INST);
                    data_data_ok = (r_owner == OWN_DATA);
                    w_state_nxt  = ARB_IDLE;
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_owner     <= OWN_DATA;
            r_bus_wr    <= 1'b0;
            r_bus_size  <= 2'd0;
            r_bus_wstrb <= '0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
        end else if (w_grant_data) begin
            r_owner     <= OWN_DATA;
            r_bus_wr    <= data_wr;
            r_bus_size  <= data_size;
            r_bus_wstrb <= data_wstrb;
            r_bus_addr  <= data_addr;
            r_bus_wdata <= data_wdata;
        end else if (w_grant_inst) begin
            r_owner     <= OWN_INST;
            r_bus_wr    <= 1'b0;
            r_bus_size  <= MEM_SIZE_W;
            r_bus_wstrb <= '0;
            r_bus_addr  <= inst_addr;
            r_bus_wdata <= '0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_inst_rdata <= '0;
            r_data_rdata <= '0;
        end else begin
            if (inst_data_ok)
                r_inst_rdata <= bus_rdata;
            if (data_data_ok)
                r_data_rdata <= bus_rdata;
        end
    end

    // Read data is forwarded in the response cycle and held afterwards
    assign inst_rdata = inst_data_ok ? bus_rdata : r_inst_rdata;
    assign data_rdata = data_data_ok ? bus_rdata : r_data_rdata;

    assign bus_req   = (r_state == ARB_REQ);
    assign bus_wr    = r_bus_wr;
    assign bus_size  = r_bus_size;
    assign bus_wstrb = r_bus_wstrb;
    assign bus_addr  = r_bus_addr;
    assign bus_wdata = r_bus_wdata;
    assign busy      = !w_idle;

endmodule
`default_nettype wire

// File: tb/tb_mem_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_req_arbiter
// Description : Directed and randomized self-checking bench for mem_req_arbiter
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_req_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int LIMIT  = 4;

    logic              aclk = 1'b0;
    logic              aresetn;
    logic              inst_req;
    logic [31:0]       inst_addr;
    logic              inst_addr_ok, inst_data_ok;
    logic [31:0]       inst_rdata;
    logic              data_req, data_wr;
    logic [1:0]        data_size;
    logic [3:0]        data_wstrb;
    logic [31:0]       data_addr, data_wdata;
    logic              data_addr_ok, data_data_ok;
    logic [31:0]       data_rdata;
    logic              bus_req, bus_wr;
    logic [1:0]        bus_size;
    logic [3:0]        bus_wstrb;
    logic [31:0]       bus_addr, bus_wdata;
    logic              bus_addr_ok, bus_data_ok;
    logic [31:0]       bus_rdata;
    logic              busy;

    int n_tests = 0;
    int n_fail  = 0;

    mem_req_arbiter #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .bus_req      (bus_req),
        .bus_wr       (bus_wr),
        .bus_size     (bus_size),
        .bus_wstrb    (bus_wstrb),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_addr_ok  (bus_addr_ok),
        .bus_data_ok  (bus_data_ok),
        .bus_rdata    (bus_rdata),
        .busy         (busy)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          s;
        int          phase;
        int          dly;
        bit          exp_d, g_d, g_i, exp_dok, drop_i, drop_d, t_inst;
        logic [70:0] t_pay;
        logic [31:0] last_i, last_d;

        aresetn = 1'b0;
        inst_req = 1'b0; inst_addr = '0;
        data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_wstrb = '0;
        data_addr = '0; data_wdata = '0;
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;

        // Reset state
        tick(); tick(); #1;
        chk("rst_busy", busy, 0);
        chk("rst_ok", {bus_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 0);
        chk("rst_payload", {bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata}, 0);
        chk("rst_rdata", {inst_rdata, data_rdata}, 0);
        tick(); aresetn = 1'b1;

        // Single fetch, bus always ready; bus_data_ok also high during REQ
        tick(); inst_req = 1'b1; inst_addr = 32'h1c00_0000;
        bus_addr_ok = 1'b1; bus_data_ok = 1'b1; #1;
        chk("t1_c0_addr_ok", {inst_addr_ok, data_addr_ok, busy}, 3'b100);
        tick(); inst_req = 1'b0; bus_rdata = 32'hcafe_0001; #1;
        chk("t1_c1_bus_req", {bus_req, busy}, 2'b11);
        chk("t1_c1_payload", {bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata},
            {1'b0, 2'd2, 4'h0, 32'h1c00_0000, 32'h0});
        chk("t1_c1_noise_ignored", {inst_data_ok, data_data_ok, inst_rdata}, 0);
        tick(); #1;
        chk("t1_c2_data_ok", {inst_data_ok, data_data_ok, bus_req}, 3'b100);
        chk("t1_c2_rdata", inst_rdata, 32'hcafe_0001);
        tick(); bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0; #1;
        chk("t1_c3_idle", {busy, inst_data_ok}, 0);
        chk("t1_c3_rdata_hold", inst_rdata, 32'hcafe_0001);

        // Both requesters held high: data wins until the starvation limit
        s = 0;
        for (int g = 0; g < 6; g++) begin
            tick(); inst_req = 1'b1; inst_addr = 32'h1c00_0100 + 32'(g * 4);
            data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_wstrb = 4'hf;
            data_addr = 32'h8000_0000 + 32'(g * 16); data_wdata = 32'(g);
            bus_addr_ok = 1'b1; bus_data_ok = 1'b1; #1;
            exp_d = (s != LIMIT);
            chk($sformatf("t3_g%0d_grant", g), {data_addr_ok, inst_addr_ok}, {exp_d, !exp_d});
            s = exp_d ? ((s < LIMIT) ? s + 1 : s) : 0;
            tick(); bus_rdata = 32'hd000_0000 + 32'(g); #1;
            chk($sformatf("t3_g%0d_addr", g), bus_addr, exp_d ? data_addr : inst_addr);
            chk($sformatf("t3_g%0d_busy_wait", g), {data_addr_ok, inst_addr_ok}, 0);
            tick(); #1;
            chk($sformatf("t3_g%0d_data_ok", g), {data_data_ok, inst_data_ok}, {exp_d, !exp_d});
        end
        tick(); inst_req = 1'b0; data_req = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b0;

        // Byte store with bus_addr_ok delayed three cycles
        tick(); data_req = 1'b1; data_wr = 1'b1; data_size = 2'd0; data_wstrb = 4'b1000;
        data_addr = 32'h8000_0003; data_wdata = 32'h1122_3344; #1;
        chk("t4_addr_ok", data_addr_ok, 1);
        for (int k = 0; k < 4; k++) begin
            tick(); data_req = 1'b0; bus_addr_ok = (k == 3); #1;
            chk($sformatf("t4_k%0d_payload", k),
                {bus_req, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata},
                {1'b1, 1'b1, 2'd0, 4'b1000, 32'h8000_0003, 32'h1122_3344});
        end
        tick(); bus_addr_ok = 1'b0; bus_data_ok = 1'b1; #1;
        chk("t4_store_done", {data_data_ok, inst_data_ok}, 2'b10);
        tick(); bus_data_ok = 1'b0;

        // Asynchronous reset while waiting for the response
        tick(); data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_wstrb = 4'h0;
        data_addr = 32'h8000_0040; #1;
        chk("t5_addr_ok", data_addr_ok, 1);
        tick(); data_req = 1'b0; bus_addr_ok = 1'b1;
        tick(); bus_addr_ok = 1'b0; #1;
        chk("t5_in_wait", {busy, bus_req}, 2'b10);
        #2; aresetn = 1'b0; #1;
        chk("t5_async_ctrl", {busy, bus_req, data_data_ok, inst_data_ok}, 0);
        chk("t5_async_payload", {bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata}, 0);
        tick(); aresetn = 1'b1;
        tick(); bus_data_ok = 1'b1; bus_rdata = 32'hbad0_bad0; #1;
        chk("t5_stale_resp", {data_data_ok, inst_data_ok, busy}, 0);
        chk("t5_rdata_cleared", data_rdata, 0);
        tick(); bus_data_ok = 1'b0; data_req = 1'b1; data_addr = 32'h8000_0080; #1;
        chk("t5_regrant", data_addr_ok, 1);
        tick(); data_req = 1'b0; bus_addr_ok = 1'b1; #1;
        chk("t5_regrant_addr", bus_addr, 32'h8000_0080);
        tick(); bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h5a5a_5a5a; #1;
        chk("t5_regrant_data", {data_data_ok, data_rdata}, {1'b1, 32'h5a5a_5a5a});
        tick(); bus_data_ok = 1'b0;

        // Randomized traffic against a transaction-level model
        s = 0; phase = 0; dly = 0; t_inst = 1'b0; t_pay = '0;
        last_i = '0; last_d = 32'h5a5a_5a5a; drop_i = 1'b0; drop_d = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (drop_i) inst_req = 1'b0;
            if (drop_d) data_req = 1'b0;
            if (!inst_req && $urandom_range(0, 2) == 0) begin
                inst_req = 1'b1; inst_addr = $urandom & 32'hffff_fffc;
            end
            if (!data_req && $urandom_range(0, 2) == 0) begin
                data_req = 1'b1; data_wr = 1'($urandom);
                data_size = 2'($urandom_range(0, 2)); data_wstrb = 4'($urandom);
                data_addr = $urandom; data_wdata = $urandom;
            end
            bus_rdata   = $urandom;
            bus_addr_ok = (phase == 1) && (dly == 0);
            bus_data_ok = (phase == 2) ? (dly == 0) : ($urandom_range(0, 3) == 0);
            #1;
            g_d = (phase == 0) && data_req && !(inst_req && LIMIT != 0 && s == LIMIT);
            g_i = (phase == 0) && inst_req && !g_d;
            exp_dok = (phase == 2) && bus_data_ok;
            chk("r_addr_ok", {inst_addr_ok, data_addr_ok}, {g_i, g_d});
            chk("r_bus_req_busy", {bus_req, busy}, {phase == 1, phase != 0});
            if (phase == 1)
                chk("r_payload", {bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata}, t_pay);
            chk("r_data_ok", {inst_data_ok, data_data_ok}, {exp_dok && t_inst, exp_dok && !t_inst});
            if (exp_dok) begin
                if (t_inst) last_i = bus_rdata;
                else        last_d = bus_rdata;
            end
            chk("r_inst_rdata", inst_rdata, last_i);
            chk("r_data_rdata", data_rdata, last_d);

            drop_i = 1'b0; drop_d = 1'b0;
            if (g_d) begin
                t_inst = 1'b0;
                t_pay  = {data_wr, data_size, data_wstrb, data_addr, data_wdata};
                s      = inst_req ? ((s < LIMIT) ? s + 1 : s) : 0;
                drop_d = 1'b1; phase = 1; dly = $urandom_range(0, 2);
            end else if (g_i) begin
                t_inst = 1'b1;
                t_pay  = {1'b0, 2'd2, 4'h0, inst_addr, 32'h0};
                s      = 0;
                drop_i = 1'b1; phase = 1; dly = $urandom_range(0, 2);
            end else if (phase == 1) begin
                if (dly == 0) begin phase = 2; dly = $urandom_range(0, 3); end
                else dly--;
            end else if (phase == 2) begin
                if (dly == 0) phase = 0;
                else dly--;
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
